// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin scheduler for the write port of an async FIFO.
// Each written word is tagged {source id, end-of-packet, payload}.

module fifo_wr_arbiter_lane #(
  parameter int IDW  = 2,
  parameter int LANE = 0
) (
  input  logic           locked,
  input  logic [IDW-1:0] grant_id,
  input  logic           wr_full,
  output logic           ready
);
  assign ready = locked & (grant_id == IDW'(LANE)) & ~wr_full;
endmodule

module fifo_wr_arbiter #(
  parameter  int DWIDTH    = 64,
  parameter  int NUM_REQ   = 4,
  parameter  int MAX_BEATS = 256,
  localparam int IDW       = $clog2(NUM_REQ),
  localparam int FWIDTH    = DWIDTH + 1 + IDW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DWIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wr_full,
  output logic                      wr_en,
  output logic [FWIDTH-1:0]         wr_data,
  output logic                      grant_vld,
  output logic [IDW-1:0]            grant_id,
  output logic                      trunc_err
);
  localparam int CW = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  beat_cnt_q, beat_cnt_d;
  logic           grant_vld_q, grant_vld_d;
  logic           trunc_err_q, trunc_err_d;

  logic           locked, accept, cnt_max, last_eff, sel_found;
  logic [IDW-1:0] sel;

  // Output gating includes rst so nothing is written in the reset cycle.
  assign locked   = (state_q == LOCKED) & ~rst;
  assign cnt_max  = (beat_cnt_q == CW'(MAX_BEATS - 1));
  assign last_eff = req_last[grant_id_q] | cnt_max;
  assign accept   = locked & req_valid[grant_id_q] & ~wr_full;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    fifo_wr_arbiter_lane #(.IDW(IDW), .LANE(gi)) u_lane (
      .locked   (locked),
      .grant_id (grant_id_q),
      .wr_full  (wr_full),
      .ready    (req_ready[gi])
    );
  end

  assign wr_en     = accept;
  assign wr_data   = {grant_id_q, last_eff, req_data[int'(grant_id_q)*DWIDTH +: DWIDTH]};
  assign grant_vld = grant_vld_q;
  assign grant_id  = grant_id_q;
  assign trunc_err = trunc_err_q;

  // First valid requester at or above rr_ptr, wrapping.
  always_comb begin
    int idx;
    sel       = '0;
    sel_found = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!sel_found && req_valid[idx]) begin
        sel_found = 1'b1;
        sel       = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    grant_vld_d = grant_vld_q;
    trunc_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_id_d  = sel;
          grant_vld_d = 1'b1;
          beat_cnt_d  = '0;
          state_d     = LOCKED;
        end
      end
      LOCKED: begin
        if (accept) begin
          if (last_eff) begin
            grant_vld_d = 1'b0;
            rr_ptr_d    = IDW'((int'(grant_id_q) + 1) % NUM_REQ);
            beat_cnt_d  = '0;
            state_d     = IDLE;
            trunc_err_d = cnt_max & ~req_last[grant_id_q];
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      grant_vld_q <= 1'b0;
      trunc_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      grant_vld_q <= grant_vld_d;
      trunc_err_q <= trunc_err_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed vector bench for fifo_wr_arbiter: 4 requesters, 16-bit payload,
// MAX_BEATS=4 so truncation is reachable with short packets.

module tb_fifo_wr_arbiter;
  localparam int DW = 16;
  localparam int NR = 4;
  localparam int MB = 4;
  localparam int FW = DW + 1 + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid, req_last, req_ready;
  logic [NR*DW-1:0] req_data;
  logic             wr_full, wr_en, grant_vld, trunc_err;
  logic [FW-1:0]    wr_data;
  logic [1:0]       grant_id;

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(.DWIDTH(DW), .NUM_REQ(NR), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .wr_full(wr_full), .wr_en(wr_en),
    .wr_data(wr_data), .grant_vld(grant_vld), .grant_id(grant_id),
    .trunc_err(trunc_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] vld, lst;
    logic       full;
    logic [3:0] rdy;
    logic       wen, gv;
    logic [1:0] gid;
    logic       last, trunc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l,
                     input logic f, input logic [3:0] rd, input logic we,
                     input logic g, input logic [1:0] id, input logic le,
                     input logic tr);
    vec_t x;
    x.rst = r; x.vld = v; x.lst = l; x.full = f; x.rdy = rd;
    x.wen = we; x.gv = g; x.gid = id; x.last = le; x.trunc = tr;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pay(input int id, input int k);
    return {4'hA, 4'(id), 8'(k)};
  endfunction

  task automatic set_data(input int k);
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = pay(i, k);
  endtask

  initial begin
    int cnt[NR];
    int exp_id, nw;
    logic [FW-1:0] exp_wd;

    rst = 1'b1; req_valid = '0; req_last = '0; wr_full = 1'b0;
    set_data(0);
    repeat (2) @(posedge clk);

    //  rst vld      lst      full rdy      wen gv gid last trunc
    // reset state, then req 2 sends a 3-beat packet
    add(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0);  // 0
    add(0, 4'b0100, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0);  // 1 grant cycle
    add(0, 4'b0100, 4'b0000, 0, 4'b0100, 1, 1, 2, 0, 0);  // 2
    add(0, 4'b0100, 4'b0000, 0, 4'b0100, 1, 1, 2, 0, 0);  // 3
    add(0, 4'b0100, 4'b0100, 0, 4'b0100, 1, 1, 2, 1, 0);  // 4
    add(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 2, 0, 0);  // 5
    // rr_ptr is 3 now: all valid picks 3, then 0
    add(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 0, 2, 0, 0);  // 6
    add(0, 4'b1111, 4'b1111, 0, 4'b1000, 1, 1, 3, 1, 0);  // 7
    add(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 0, 3, 0, 0);  // 8
    add(0, 4'b1111, 4'b1111, 0, 4'b0001, 1, 1, 0, 1, 0);  // 9
    // backpressure during beat 2 of a 4-beat packet from req 1
    add(0, 4'b0010, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0);  // 10
    add(0, 4'b0010, 4'b0000, 0, 4'b0010, 1, 1, 1, 0, 0);  // 11
    for (int i = 0; i < 5; i++)
      add(0, 4'b0010, 4'b0000, 1, 4'b0000, 0, 1, 1, 0, 0);  // 12..16
    add(0, 4'b0010, 4'b0000, 0, 4'b0010, 1, 1, 1, 0, 0);  // 17
    add(0, 4'b0010, 4'b0000, 0, 4'b0010, 1, 1, 1, 0, 0);  // 18
    add(0, 4'b0010, 4'b0010, 0, 4'b0010, 1, 1, 1, 1, 0);  // 19
    add(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 1, 0, 0);  // 20
    // truncation: req 1 sends 6 beats, req 0 and 3 wait
    add(0, 4'b0010, 4'b0000, 0, 4'b0000, 0, 0, 1, 0, 0);  // 21
    add(0, 4'b1011, 4'b0000, 0, 4'b0010, 1, 1, 1, 0, 0);  // 22
    add(0, 4'b1011, 4'b0000, 0, 4'b0010, 1, 1, 1, 0, 0);  // 23
    add(0, 4'b1011, 4'b0000, 0, 4'b0010, 1, 1, 1, 0, 0);  // 24
    add(0, 4'b1011, 4'b0000, 0, 4'b0010, 1, 1, 1, 1, 0);  // 25 forced last
    add(0, 4'b1011, 4'b1000, 0, 4'b0000, 0, 0, 1, 0, 1);  // 26 trunc pulse
    add(0, 4'b1011, 4'b1000, 0, 4'b1000, 1, 1, 3, 1, 0);  // 27
    add(0, 4'b1011, 4'b1001, 0, 4'b0000, 0, 0, 3, 0, 0);  // 28
    add(0, 4'b1011, 4'b1001, 0, 4'b0001, 1, 1, 0, 1, 0);  // 29
    add(0, 4'b0010, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0);  // 30
    add(0, 4'b0010, 4'b0000, 0, 4'b0010, 1, 1, 1, 0, 0);  // 31 beat 5
    add(0, 4'b0010, 4'b0010, 0, 4'b0010, 1, 1, 1, 1, 0);  // 32 beat 6
    add(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 1, 0, 0);  // 33
    // valid gap on req 3 while req 0 waits
    add(0, 4'b1000, 4'b0000, 0, 4'b0000, 0, 0, 1, 0, 0);  // 34
    add(0, 4'b1001, 4'b0000, 0, 4'b1000, 1, 1, 3, 0, 0);  // 35
    for (int i = 0; i < 3; i++)
      add(0, 4'b0001, 4'b0000, 0, 4'b1000, 0, 1, 3, 0, 0);  // 36..38
    add(0, 4'b1001, 4'b1000, 0, 4'b1000, 1, 1, 3, 1, 0);  // 39
    add(0, 4'b0001, 4'b0001, 0, 4'b0000, 0, 0, 3, 0, 0);  // 40
    add(0, 4'b0001, 4'b0001, 0, 4'b0001, 1, 1, 0, 1, 0);  // 41
    // reset after beat 2 of a 5-beat packet from req 2
    add(0, 4'b0100, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0);  // 42
    add(0, 4'b0100, 4'b0000, 0, 4'b0100, 1, 1, 2, 0, 0);  // 43
    add(0, 4'b0100, 4'b0000, 0, 4'b0100, 1, 1, 2, 0, 0);  // 44
    add(1, 4'b0100, 4'b0000, 0, 4'b0000, 0, 1, 2, 0, 0);  // 45
    add(0, 4'b0101, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0);  // 46 rr restarts at 0
    add(0, 4'b0101, 4'b0101, 0, 4'b0001, 1, 1, 0, 1, 0);  // 47

    foreach (vecs[k]) begin
      @(negedge clk);
      rst = vecs[k].rst; req_valid = vecs[k].vld; req_last = vecs[k].lst;
      wr_full = vecs[k].full;
      set_data(k);
      #1;
      chk("req_ready", k, 32'(req_ready), 32'(vecs[k].rdy));
      chk("wr_en",     k, 32'(wr_en),     32'(vecs[k].wen));
      chk("grant_vld", k, 32'(grant_vld), 32'(vecs[k].gv));
      chk("grant_id",  k, 32'(grant_id),  32'(vecs[k].gid));
      chk("trunc_err", k, 32'(trunc_err), 32'(vecs[k].trunc));
      if (vecs[k].wen) begin
        exp_wd = {vecs[k].gid, vecs[k].last, pay(int'(vecs[k].gid), k)};
        chk("wr_data", k, 32'(wr_data), 32'(exp_wd));
      end
    end

    // Fairness: all requesters stream single-beat packets after a fresh reset.
    @(negedge clk); rst = 1'b1; req_valid = '0; req_last = '0;
    @(negedge clk); rst = 1'b0; req_valid = 4'b1111; req_last = 4'b1111;
    foreach (cnt[i]) cnt[i] = 0;
    exp_id = 0; nw = 0;
    for (int c = 0; c < 200; c++) begin
      #1;
      chk("rr_wr_en", c, 32'(wr_en), 32'(c % 2));
      if (wr_en) begin
        chk("rr_id", c, 32'(wr_data[FW-1 -: 2]), 32'(exp_id));
        cnt[wr_data[FW-1 -: 2]]++;
        exp_id = (exp_id + 1) % NR;
        nw++;
      end
      @(negedge clk);
    end
    chk("rr_total", 0, 32'(nw), 32'd100);
    for (int i = 0; i < NR; i++) chk("rr_share", i, 32'(cnt[i]), 32'd25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
